// File: rtl/spi_master_pkg.sv
// Shared state encoding, shifter-select codes and phase-ordering helper
// for the SPI master transaction sequencer.
package spi_master_pkg;

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, DUMMY, DATA_TX, DATA_RX, STOP
    } state_t;

    localparam logic [1:0] TX_SEL_CMD  = 2'd0;
    localparam logic [1:0] TX_SEL_ADDR = 2'd1;
    localparam logic [1:0] TX_SEL_DATA = 2'd2;

    localparam int STOP_HOLD = 2;

    // Later checks override earlier ones, so the earliest non-empty phase after 'from' wins.
    function automatic state_t next_phase(input state_t from, input logic has_cmd,
                                          input logic has_addr, input logic has_dummy,
                                          input logic has_data, input logic wr);
        state_t nxt;
        nxt = STOP;
        if (has_data && (from inside {IDLE, CMD, ADDR, DUMMY})) nxt = wr ? DATA_TX : DATA_RX;
        if (has_dummy && (from inside {IDLE, CMD, ADDR}))       nxt = DUMMY;
        if (has_addr && (from inside {IDLE, CMD}))              nxt = ADDR;
        if (has_cmd && (from == IDLE))                          nxt = CMD;
        return nxt;
    endfunction

endpackage

// File: rtl/spi_master_seq_divq.sv
// One-entry holding register for clock-divider updates: forwards at once when
// idle, otherwise keeps the newest request and issues it when the bus goes idle.
module spi_master_seq_divq (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] cfg_div,
    input  logic       cfg_div_valid,
    input  logic       busy,
    input  logic       release_i,
    output logic [7:0] clk_div,
    output logic       clk_div_valid
);

    logic [7:0] pend_q, pend_d, clk_div_q, clk_div_d;
    logic       pend_vld_q, pend_vld_d, clk_div_valid_q, clk_div_valid_d;

    always_comb begin
        pend_d          = pend_q;
        pend_vld_d      = pend_vld_q;
        clk_div_d       = clk_div_q;
        clk_div_valid_d = 1'b0;
        if (cfg_div_valid && !busy) begin
            clk_div_d       = cfg_div;
            clk_div_valid_d = 1'b1;
        end else if (release_i && (pend_vld_q || cfg_div_valid)) begin
            // A request landing in the release cycle is newer than the stored one.
            clk_div_d       = cfg_div_valid ? cfg_div : pend_q;
            clk_div_valid_d = 1'b1;
            pend_vld_d      = 1'b0;
        end else if (cfg_div_valid) begin
            pend_d     = cfg_div;
            pend_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_q          <= '0;
            pend_vld_q      <= 1'b0;
            clk_div_q       <= '0;
            clk_div_valid_q <= 1'b0;
        end else begin
            pend_q          <= pend_d;
            pend_vld_q      <= pend_vld_d;
            clk_div_q       <= clk_div_d;
            clk_div_valid_q <= clk_div_valid_d;
        end
    end

    assign clk_div       = clk_div_q;
    assign clk_div_valid = clk_div_valid_q;

endmodule

// File: rtl/spi_master_seq.sv
// SPI transaction sequencer: walks CS-assert, cmd, addr, dummy, data, CS-release
// phases, strobing the shifters and gating the clock generator.
module spi_master_seq
    import spi_master_pkg::*;
#(
    parameter int NCS     = 4,
    parameter int DUMMY_W = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   wr,
    input  logic [$clog2(NCS)-1:0] cs_sel,
    input  logic [5:0]             cmd_len,
    input  logic [5:0]             addr_len,
    input  logic [DUMMY_W-1:0]     dummy_len,
    input  logic [15:0]            data_len,
    input  logic [7:0]             cfg_div,
    input  logic                   cfg_div_valid,
    output logic [7:0]             clk_div,
    output logic                   clk_div_valid,
    output logic                   clk_en,
    input  logic                   spi_rise,
    input  logic                   spi_fall,
    output logic                   tx_start,
    output logic [15:0]            tx_len,
    output logic [1:0]             tx_sel,
    input  logic                   tx_done,
    output logic                   rx_start,
    output logic [15:0]            rx_len,
    input  logic                   rx_done,
    output logic [NCS-1:0]         spi_csn,
    output logic                   busy,
    output logic                   eot
);

    state_t               state_q, state_d, nxt;
    logic [5:0]           cmd_len_q, cmd_len_d, addr_len_q, addr_len_d, c_len, a_len;
    logic [DUMMY_W-1:0]   dummy_len_q, dummy_len_d, dcnt_q, dcnt_d, d_len;
    logic [15:0]          data_len_q, data_len_d, tx_len_q, tx_len_d, rx_len_q, rx_len_d, n_len;
    logic [1:0]           scnt_q, scnt_d, tx_sel_q, tx_sel_d;
    logic [NCS-1:0]       csn_q, csn_d;
    logic                 wr_q, wr_d, w, advance;
    logic                 clk_en_q, clk_en_d, busy_q, busy_d, eot_q, eot_d;
    logic                 tx_start_q, tx_start_d, rx_start_q, rx_start_d;

    // In IDLE the phase plan comes straight from the request so the first strobe is not delayed.
    always_comb begin
        c_len = (state_q == IDLE) ? cmd_len   : cmd_len_q;
        a_len = (state_q == IDLE) ? addr_len  : addr_len_q;
        d_len = (state_q == IDLE) ? dummy_len : dummy_len_q;
        n_len = (state_q == IDLE) ? data_len  : data_len_q;
        w     = (state_q == IDLE) ? wr        : wr_q;
        nxt   = next_phase(state_q, c_len != '0, a_len != '0, d_len != '0, n_len != '0, w);
    end

    always_comb begin
        state_d     = state_q;
        cmd_len_d   = cmd_len_q;
        addr_len_d  = addr_len_q;
        dummy_len_d = dummy_len_q;
        data_len_d  = data_len_q;
        wr_d        = wr_q;
        dcnt_d      = dcnt_q;
        scnt_d      = scnt_q;
        csn_d       = csn_q;
        clk_en_d    = clk_en_q;
        busy_d      = busy_q;
        tx_len_d    = tx_len_q;
        tx_sel_d    = tx_sel_q;
        rx_len_d    = rx_len_q;
        tx_start_d  = 1'b0;
        rx_start_d  = 1'b0;
        eot_d       = 1'b0;
        advance     = 1'b0;
        if (eot_q) busy_d = 1'b0;
        if (abort && state_q != IDLE && state_q != STOP) begin
            state_d  = STOP;
            clk_en_d = 1'b0;
            scnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (start && !abort && !busy_q) begin
                    cmd_len_d   = cmd_len;
                    addr_len_d  = addr_len;
                    dummy_len_d = dummy_len;
                    data_len_d  = data_len;
                    wr_d        = wr;
                    csn_d       = ~(NCS'(1) << cs_sel);
                    clk_en_d    = 1'b1;
                    busy_d      = 1'b1;
                    advance     = 1'b1;
                end
                CMD, ADDR, DATA_TX: advance = tx_done;
                DATA_RX:            advance = rx_done;
                DUMMY: if (spi_rise) begin
                    // Compare before increment so the counter never has to hold dummy_len.
                    if (dcnt_q == dummy_len_q - DUMMY_W'(1)) advance = 1'b1;
                    else dcnt_d = dcnt_q + DUMMY_W'(1);
                end
                STOP: begin
                    clk_en_d = 1'b0;
                    if (spi_rise || spi_fall) scnt_d = '0;
                    else if (scnt_q == 2'(STOP_HOLD - 1)) begin
                        state_d = IDLE;
                        csn_d   = '1;
                        eot_d   = 1'b1;
                        scnt_d  = '0;
                    end else scnt_d = scnt_q + 2'd1;
                end
                default: state_d = IDLE;
            endcase
            if (advance) begin
                state_d = nxt;
                case (nxt)
                    CMD: begin
                        tx_start_d = 1'b1;
                        tx_len_d   = 16'(c_len) - 16'd1;
                        tx_sel_d   = TX_SEL_CMD;
                    end
                    ADDR: begin
                        tx_start_d = 1'b1;
                        tx_len_d   = 16'(a_len) - 16'd1;
                        tx_sel_d   = TX_SEL_ADDR;
                    end
                    DATA_TX: begin
                        tx_start_d = 1'b1;
                        tx_len_d   = n_len - 16'd1;
                        tx_sel_d   = TX_SEL_DATA;
                    end
                    DATA_RX: begin
                        rx_start_d = 1'b1;
                        rx_len_d   = n_len - 16'd1;
                    end
                    DUMMY:   dcnt_d = '0;
                    // An empty request still shows clk_en for its accept cycle; STOP drops it.
                    default: if (state_q != IDLE) clk_en_d = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cmd_len_q   <= '0;
            addr_len_q  <= '0;
            dummy_len_q <= '0;
            data_len_q  <= '0;
            wr_q        <= 1'b0;
            dcnt_q      <= '0;
            scnt_q      <= '0;
            csn_q       <= '1;
            clk_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            eot_q       <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_len_q    <= '0;
            tx_sel_q    <= '0;
            rx_start_q  <= 1'b0;
            rx_len_q    <= '0;
        end else begin
            state_q     <= state_d;
            cmd_len_q   <= cmd_len_d;
            addr_len_q  <= addr_len_d;
            dummy_len_q <= dummy_len_d;
            data_len_q  <= data_len_d;
            wr_q        <= wr_d;
            dcnt_q      <= dcnt_d;
            scnt_q      <= scnt_d;
            csn_q       <= csn_d;
            clk_en_q    <= clk_en_d;
            busy_q      <= busy_d;
            eot_q       <= eot_d;
            tx_start_q  <= tx_start_d;
            tx_len_q    <= tx_len_d;
            tx_sel_q    <= tx_sel_d;
            rx_start_q  <= rx_start_d;
            rx_len_q    <= rx_len_d;
        end
    end

    spi_master_seq_divq u_divq (
        .clk           (clk),
        .rstn          (rstn),
        .cfg_div       (cfg_div),
        .cfg_div_valid (cfg_div_valid),
        .busy          (busy_q),
        .release_i     (eot_q),
        .clk_div       (clk_div),
        .clk_div_valid (clk_div_valid)
    );

    assign spi_csn  = csn_q;
    assign clk_en   = clk_en_q;
    assign busy     = busy_q;
    assign eot      = eot_q;
    assign tx_start = tx_start_q;
    assign tx_len   = tx_len_q;
    assign tx_sel   = tx_sel_q;
    assign rx_start = rx_start_q;
    assign rx_len   = rx_len_q;

endmodule
